// File: rtl/w_buf_pkg.sv
// Shared definitions for the weight-buffer sequencer and the w_buf instance.
// Holds the buffer geometry constants and the sequencer FSM state encoding.
// No ports; imported by w_buf_ctrl_if, w_buf_ctrl and the w_buf instantiation.
package w_buf_pkg;

  localparam int W_DEPTH      = 16;
  localparam int W_ADDR_WIDTH = $clog2(W_DEPTH);
  localparam int W_REP_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } w_state_e;

endpackage

// File: rtl/w_buf_ctrl_if.sv
// Bundle of the layer-controller command/status and w_buf/PE-array stream signals.
// master: the sequencer side (drives buffer enable/address, valid/last, busy/done).
// slave: the environment side (drives start, config and the downstream ready).
interface w_buf_ctrl_if
  import w_buf_pkg::*;
#(
  parameter int ADDR_WIDTH = W_ADDR_WIDTH,
  parameter int REP_WIDTH  = W_REP_WIDTH
) ();

  // command / configuration from the layer controller
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [ADDR_WIDTH:0]   num_rows_i;
  logic [REP_WIDTH-1:0]  repeat_i;
  // downstream acceptance of the current beat
  logic                  ready_i;
  // buffer read port and stream qualifiers
  logic                  w_buf_en_o;
  logic [ADDR_WIDTH-1:0] w_buf_addr_o;
  logic                  w_valid_o;
  logic                  w_last_o;
  // status back to the layer controller
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  start_i, base_addr_i, num_rows_i, repeat_i, ready_i,
    output w_buf_en_o, w_buf_addr_o, w_valid_o, w_last_o, busy_o, done_o
  );

  modport slave (
    output start_i, base_addr_i, num_rows_i, repeat_i, ready_i,
    input  w_buf_en_o, w_buf_addr_o, w_valid_o, w_last_o, busy_o, done_o
  );

endinterface

// File: rtl/w_buf_ctrl.sv
// Weight-buffer sequencer: on start, streams num_rows rows from a wrapping
// base address, repeat times, to the PE array with a valid/ready handshake.
// Ports: clk, rst_i (sync, active-high), bus (w_buf_ctrl_if.master: start/config
// in, ready in, w_buf enable/address out, valid/last out, busy/done out).
// Latency: first read one cycle after start, data valid the cycle after that;
// one row per cycle with ready held high. Backpressure: while a beat is stalled
// the buffer keeps being enabled at the stalled beat's address so its data holds.
module w_buf_ctrl
  import w_buf_pkg::*;
#(
  parameter int DEPTH      = W_DEPTH,
  parameter int ADDR_WIDTH = W_ADDR_WIDTH,
  parameter int REP_WIDTH  = W_REP_WIDTH
) (
  input  logic          clk,
  input  logic          rst_i,
  w_buf_ctrl_if.master  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ROW_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [REP_WIDTH-1:0]  REP_ONE   = REP_WIDTH'(1);

  w_state_e state, state_nxt;

  // latched configuration
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   rows_q;
  logic [REP_WIDTH-1:0]  rep_q;
  // walk state
  logic [ADDR_WIDTH-1:0] ptr_q;      // next row to issue
  logic [ADDR_WIDTH-1:0] hold_q;     // address of the beat now on w_valid_o
  logic [ADDR_WIDTH:0]   row_cnt_q;
  logic [REP_WIDTH-1:0]  pass_cnt_q;
  logic                  valid_q;
  logic                  last_q;

  logic stall;
  logic issue;
  logic row_end;
  logic run_end;
  logic zero_cfg;

  assign stall    = valid_q && !bus.ready_i;
  assign issue    = (state == ST_RUN) && !stall;
  assign row_end  = (row_cnt_q == rows_q - ROW_ONE);
  assign run_end  = row_end && (pass_cnt_q == rep_q - REP_ONE);
  assign zero_cfg = (bus.num_rows_i == '0) || (bus.repeat_i == '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          state_nxt = zero_cfg ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue && run_end) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // valid_q is always set here: the final beat waits for its accept
        if (valid_q && bus.ready_i) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // In RUN the buffer is enabled every cycle: either a fresh issue at the
  // pointer, or a stall re-read of the held beat, because w_buf zeroes its
  // output when its enable drops.
  always_comb begin
    bus.w_buf_en_o   = 1'b0;
    bus.w_buf_addr_o = '0;
    bus.busy_o       = 1'b0;
    bus.done_o       = 1'b0;
    case (state)
      ST_RUN: begin
        bus.w_buf_en_o   = 1'b1;
        bus.w_buf_addr_o = issue ? ptr_q : hold_q;
        bus.busy_o       = 1'b1;
      end
      ST_DRAIN: begin
        bus.w_buf_en_o   = 1'b1;
        bus.w_buf_addr_o = hold_q;
        bus.busy_o       = 1'b1;
      end
      ST_DONE: begin
        bus.done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.w_valid_o = valid_q;
  assign bus.w_last_o  = last_q;

  // ---------------- config, pointer and counters ----------------
  always_ff @(posedge clk) begin
    if (rst_i) begin
      base_q     <= '0;
      rows_q     <= '0;
      rep_q      <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      row_cnt_q  <= '0;
      pass_cnt_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && bus.start_i) begin
        base_q     <= bus.base_addr_i;
        rows_q     <= bus.num_rows_i;
        rep_q      <= bus.repeat_i;
        ptr_q      <= bus.base_addr_i;
        row_cnt_q  <= '0;
        pass_cnt_q <= '0;
      end

      if (issue) begin
        hold_q <= ptr_q;
        if (row_end) begin
          // next pass restarts at base with no bubble
          ptr_q      <= base_q;
          row_cnt_q  <= '0;
          pass_cnt_q <= pass_cnt_q + REP_ONE;
        end else begin
          ptr_q     <= (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_ONE;
          row_cnt_q <= row_cnt_q + ROW_ONE;
        end
      end

      // valid/last follow the read by one cycle and freeze across a stall
      valid_q <= issue || stall;
      if (issue) begin
        last_q <= row_end;
      end else if (!stall) begin
        last_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_w_buf_ctrl.sv
// Bench for w_buf_ctrl: a w_buf read model plus a queue of expected beats built
// from base/rows/repeat; every valid cycle is checked against the queue head.
// Directed tests add hand-computed cycle-exact expectations.
module tb_w_buf_ctrl;
  import w_buf_pkg::*;

  localparam int AW = W_ADDR_WIDTH;
  localparam int RW = W_REP_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  w_buf_ctrl_if bus ();

  w_buf_ctrl dut (
    .clk   (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // w_buf model: registered read, output zero whenever enable is low
  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  logic [7:0] rdata;
  always_ff @(posedge clk) begin
    rdata <= bus.w_buf_en_o ? pat(bus.w_buf_addr_o) : 8'h00;
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] acc_addr[$];
  int            checks    = 0;
  int            failures  = 0;
  int            acc_cnt   = 0;
  int            last_cnt  = 0;
  int            done_cnt  = 0;
  bit            chk_en    = 1'b0;
  int            wrap_lit[8] = '{14, 15, 0, 1, 14, 15, 0, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // expected beats: pass-major, row-minor, addresses wrap modulo depth
  task automatic load_model(input int b, input int n, input int r);
    beat_t bt;
    for (int p = 0; p < r; p++) begin
      for (int k = 0; k < n; k++) begin
        bt.addr = AW'((b + k) % W_DEPTH);
        bt.last = (k == n - 1);
        exp_q.push_back(bt);
      end
    end
  endtask

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      if (bus.w_valid_o) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", bus.w_valid_o, 0);
        end else begin
          check("beat_data", rdata, pat(exp_q[0].addr));
          check("beat_last", bus.w_last_o, exp_q[0].last);
          if (!bus.ready_i) begin
            check("stall_en", bus.w_buf_en_o, 1);
            check("stall_addr", bus.w_buf_addr_o, exp_q[0].addr);
          end else begin
            acc_addr.push_back(rdata[AW-1:0]);
            acc_cnt++;
            if (bus.w_last_o) last_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (!bus.busy_o) begin
        check("idle_en", bus.w_buf_en_o, 0);
        check("idle_addr", bus.w_buf_addr_o, 0);
      end
      if (bus.done_o) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // called just after an edge; returns one ns into cycle 1
  task automatic issue_start(input int b, input int n, input int r);
    bus.base_addr_i = AW'(b);
    bus.num_rows_i  = (AW + 1)'(n);
    bus.repeat_i    = RW'(r);
    bus.start_i     = 1'b1;
    tick();
    bus.start_i     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      cyc = i + 1;
      if (bus.done_o) seen = 1'b1;
    end
    check({name, "_done_seen"}, seen, 1);
    tick();
  endtask

  task automatic end_test(input string name, input int d0, input int a0, input int beats);
    tick();
    tick();
    check({name, "_done_cnt"}, done_cnt - d0, 1);
    check({name, "_beats"}, acc_cnt - a0, beats);
    check({name, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int d0, a0, l0, cyc;
    rst             = 1'b1;
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.num_rows_i  = '0;
    bus.repeat_i    = '0;
    bus.ready_i     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_en", bus.w_buf_en_o, 0);
    check("rst_addr", bus.w_buf_addr_o, 0);
    check("rst_valid", bus.w_valid_o, 0);
    check("rst_last", bus.w_last_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    tick();

    // basic stream: base 3, 4 rows, 1 pass
    d0 = done_cnt; a0 = acc_cnt;
    load_model(3, 4, 1);
    issue_start(3, 4, 1);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check("basic_en", bus.w_buf_en_o, (c <= 5));
      if (c <= 5) check("basic_addr", bus.w_buf_addr_o, (c <= 4) ? c + 2 : 6);
      check("basic_valid", bus.w_valid_o, (c >= 2 && c <= 5));
      check("basic_last", bus.w_last_o, (c == 5));
      check("basic_done", bus.done_o, (c == 6));
      check("basic_busy", bus.busy_o, (c <= 5));
    end
    tick();
    end_test("basic", d0, a0, 4);

    // wrap and repeat: base 14, 4 rows, 2 passes
    d0 = done_cnt; a0 = acc_cnt; l0 = last_cnt;
    acc_addr.delete();
    load_model(14, 4, 2);
    issue_start(14, 4, 2);
    wait_done("wrap", 40, cyc);
    check("wrap_done_cycle", cyc, 10);
    end_test("wrap", d0, a0, 8);
    check("wrap_lasts", last_cnt - l0, 2);
    check("wrap_seq_len", acc_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < acc_addr.size()) check("wrap_seq", acc_addr[i], wrap_lit[i]);
    end

    // backpressure on beat 2 and during drain: base 5, 3 rows, 2 passes
    d0 = done_cnt; a0 = acc_cnt;
    load_model(5, 3, 2);
    issue_start(5, 3, 2);
    for (int c = 1; c <= 14; c++) begin
      bus.ready_i = !(c inside {3, 4, 5, 10, 11});
      @(negedge clk);
      if (c == 4) begin
        check("bp_stall_en", bus.w_buf_en_o, 1);
        check("bp_stall_addr", bus.w_buf_addr_o, 6);
        check("bp_stall_valid", bus.w_valid_o, 1);
        check("bp_stall_data", rdata, pat(4'd6));
      end
      if (c == 11) begin
        check("bp_drain_busy", bus.busy_o, 1);
        check("bp_drain_valid", bus.w_valid_o, 1);
        check("bp_drain_last", bus.w_last_o, 1);
        check("bp_drain_addr", bus.w_buf_addr_o, 7);
      end
      if (c == 12 || c == 13) check("bp_done", bus.done_o, (c == 13));
      tick();
    end
    bus.ready_i = 1'b1;
    end_test("bp", d0, a0, 6);

    // zero-length configs: rows=0, then repeat=0
    for (int z = 0; z < 2; z++) begin
      d0 = done_cnt;
      issue_start(z == 0 ? 2 : 4, z == 0 ? 0 : 4, z == 0 ? 3 : 0);
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        check("zero_en", bus.w_buf_en_o, 0);
        check("zero_done", bus.done_o, (c == 1));
        check("zero_busy", bus.busy_o, 0);
      end
      tick();
      check("zero_done_cnt", done_cnt - d0, 1);
    end

    // start while busy is ignored
    d0 = done_cnt; a0 = acc_cnt;
    load_model(2, 5, 1);
    issue_start(2, 5, 1);
    tick();
    bus.base_addr_i = AW'(9);
    bus.num_rows_i  = (AW + 1)'(2);
    bus.repeat_i    = RW'(3);
    bus.start_i     = 1'b1;
    tick();
    bus.start_i     = 1'b0;
    wait_done("busy_start", 40, cyc);
    check("busy_start_done_cycle", cyc + 2, 7);
    end_test("busy_start", d0, a0, 5);

    // reset during a stall, then a fresh run
    d0 = done_cnt;
    load_model(0, 6, 1);
    issue_start(0, 6, 1);
    tick();
    tick();
    bus.ready_i = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    check("rst_mid_stalled", bus.w_valid_o, 1);
    tick();
    @(negedge clk);
    check("rst_mid_en", bus.w_buf_en_o, 0);
    check("rst_mid_addr", bus.w_buf_addr_o, 0);
    check("rst_mid_valid", bus.w_valid_o, 0);
    check("rst_mid_last", bus.w_last_o, 0);
    check("rst_mid_busy", bus.busy_o, 0);
    check("rst_mid_done", bus.done_o, 0);
    exp_q.delete();
    tick();
    rst         = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    check("rst_mid_no_done", done_cnt - d0, 0);
    d0 = done_cnt; a0 = acc_cnt;
    load_model(15, 3, 1);
    issue_start(15, 3, 1);
    wait_done("post_rst", 40, cyc);
    check("post_rst_done_cycle", cyc, 5);
    end_test("post_rst", d0, a0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
